// File: rtl/adsr_env.sv
// ADSR envelope generator: 16-bit accumulator stepped on a prescaled tick.
// Gate edges move between phases immediately. When an edge and a tick land on
// the same clock, the edge takes effect and the level is not stepped.
module adsr_env #(
    parameter int unsigned TICK_DIV = 500
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       gate,
    input  logic [7:0] attack_rate,
    input  logic [7:0] decay_rate,
    input  logic [7:0] sustain_level,
    input  logic [7:0] release_rate,
    output logic [7:0] env,
    output logic [2:0] state,
    output logic       active
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ATTACK  = 3'd1,
        S_DECAY   = 3'd2,
        S_SUSTAIN = 3'd3,
        S_RELEASE = 3'd4
    } state_t;

    localparam logic [15:0] TICK_LAST = 16'(TICK_DIV - 1);

    state_t      state_q;
    logic [15:0] acc_q;
    logic [15:0] cnt_q;
    logic        gate_q;

    logic        tick;
    logic        rise;
    logic        fall;
    logic [7:0]  rate;
    logic [15:0] step;
    logic [15:0] target;
    logic [16:0] sum;
    logic [16:0] diff;

    always_comb begin
        tick   = (cnt_q == TICK_LAST);
        rise   = gate & ~gate_q;
        fall   = ~gate & gate_q;
        rate   = '0;
        case (state_q)
            S_ATTACK:  rate = attack_rate;
            S_DECAY:   rate = decay_rate;
            S_RELEASE: rate = release_rate;
            default:   rate = '0;
        endcase
        step   = {4'b0000, rate, 4'b0000};
        target = {sustain_level, 8'h00};
        // 17-bit arithmetic exposes carry (attack) and borrow (decay)
        sum    = {1'b0, acc_q} + {1'b0, step};
        diff   = {1'b0, acc_q} - {1'b0, step};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            gate_q  <= 1'b0;
        end else begin
            cnt_q  <= tick ? '0 : cnt_q + 16'd1;
            gate_q <= gate;
            if (rise) begin
                state_q <= S_ATTACK;
            end else if (fall && (state_q == S_ATTACK || state_q == S_DECAY ||
                                  state_q == S_SUSTAIN)) begin
                state_q <= S_RELEASE;
            end else begin
                case (state_q)
                    S_IDLE: acc_q <= '0;
                    S_ATTACK: if (tick) begin
                        if (attack_rate == 8'd0 || sum[16] || sum[15:0] == 16'hFFFF) begin
                            acc_q   <= '1;
                            state_q <= S_DECAY;
                        end else begin
                            acc_q <= sum[15:0];
                        end
                    end
                    S_DECAY: if (tick) begin
                        if (decay_rate == 8'd0 || diff[16] || diff[15:0] <= target) begin
                            acc_q   <= target;
                            state_q <= S_SUSTAIN;
                        end else begin
                            acc_q <= diff[15:0];
                        end
                    end
                    S_SUSTAIN: acc_q <= target;
                    S_RELEASE: if (tick) begin
                        if (release_rate == 8'd0 || acc_q <= step) begin
                            acc_q   <= '0;
                            state_q <= S_IDLE;
                        end else begin
                            acc_q <= diff[15:0];
                        end
                    end
                    default: begin
                        acc_q   <= '0;
                        state_q <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign env    = acc_q[15:8];
    assign state  = state_q;
    assign active = (state_q != S_IDLE);

endmodule

// File: tb/tb_adsr_env.sv
// Directed bench for adsr_env with TICK_DIV = 4; the bench tracks tick timing
// with its own prescaler copy and checks each phase with hand-derived values.
module tb_adsr_env;

    logic       clk;
    logic       reset;
    logic       gate;
    logic [7:0] attack_rate;
    logic [7:0] decay_rate;
    logic [7:0] sustain_level;
    logic [7:0] release_rate;
    logic [7:0] env;
    logic [2:0] state;
    logic       active;

    int unsigned checks;
    int unsigned errors;
    int unsigned tb_cnt;

    adsr_env #(.TICK_DIV(4)) dut (
        .clk           (clk),
        .reset         (reset),
        .gate          (gate),
        .attack_rate   (attack_rate),
        .decay_rate    (decay_rate),
        .sustain_level (sustain_level),
        .release_rate  (release_rate),
        .env           (env),
        .state         (state),
        .active        (active)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bench-side prescaler: tb_cnt == 3 means the coming posedge is a tick.
    always @(posedge clk) begin
        if (reset) tb_cnt <= 0;
        else       tb_cnt <= (tb_cnt == 3) ? 0 : tb_cnt + 1;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic to_pre_tick();
        for (int i = 0; i < 8 && tb_cnt != 3; i++) @(negedge clk);
    endtask

    task automatic after_tick();
        to_pre_tick();
        @(negedge clk);
    endtask

    task automatic off_tick();
        if (tb_cnt == 3) @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1; gate = 1'b0;
        attack_rate = 8'h10; decay_rate = 8'h80;
        sustain_level = 8'h40; release_rate = 8'h40;
        repeat (3) @(negedge clk);
        checks++; if (env !== 8'h00) begin errors++; $display("FAIL reset_env: got %h want 00", env); end
        checks++; if (state !== 3'd0) begin errors++; $display("FAIL reset_state: got %0d want 0", state); end
        checks++; if (active !== 1'b0) begin errors++; $display("FAIL reset_active: got %b want 0", active); end
        reset = 1'b0;
    endtask

    task automatic test_attack();
        off_tick();
        gate = 1'b1;
        @(negedge clk);
        checks++; if (state !== 3'd1) begin errors++; $display("FAIL attack_enter_state: got %0d want 1", state); end
        checks++; if (env !== 8'h00) begin errors++; $display("FAIL attack_enter_env: got %h want 00", env); end
        checks++; if (active !== 1'b1) begin errors++; $display("FAIL attack_active: got %b want 1", active); end
        for (int i = 1; i <= 255; i++) begin
            after_tick();
            checks++; if (env !== 8'(i)) begin errors++; $display("FAIL attack_ramp tick %0d: got %h want %h", i, env, 8'(i)); end
        end
        checks++; if (state !== 3'd1) begin errors++; $display("FAIL attack_pre_sat_state: got %0d want 1", state); end
        after_tick();
        checks++; if (env !== 8'hFF) begin errors++; $display("FAIL attack_sat_env: got %h want ff", env); end
        checks++; if (state !== 3'd2) begin errors++; $display("FAIL attack_to_decay: got %0d want 2", state); end
    endtask

    task automatic test_decay();
        logic [15:0] exp_acc;
        exp_acc = 16'hFFFF;
        for (int k = 1; k <= 23; k++) begin
            after_tick();
            exp_acc = exp_acc - 16'h0800;
            checks++; if (env !== exp_acc[15:8]) begin errors++; $display("FAIL decay_step %0d: got %h want %h", k, env, exp_acc[15:8]); end
        end
        checks++; if (state !== 3'd2) begin errors++; $display("FAIL decay_state: got %0d want 2", state); end
        after_tick();
        checks++; if (env !== 8'h40) begin errors++; $display("FAIL decay_clamp: got %h want 40", env); end
        checks++; if (state !== 3'd3) begin errors++; $display("FAIL decay_to_sustain: got %0d want 3", state); end
        sustain_level = 8'h20;
        @(negedge clk);
        checks++; if (env !== 8'h20) begin errors++; $display("FAIL sustain_track_down: got %h want 20", env); end
        sustain_level = 8'h40;
        @(negedge clk);
        checks++; if (env !== 8'h40) begin errors++; $display("FAIL sustain_track_up: got %h want 40", env); end
    endtask

    task automatic test_release();
        off_tick();
        gate = 1'b0;
        @(negedge clk);
        checks++; if (state !== 3'd4) begin errors++; $display("FAIL release_enter_state: got %0d want 4", state); end
        checks++; if (env !== 8'h40) begin errors++; $display("FAIL release_enter_env: got %h want 40", env); end
        for (int k = 1; k <= 15; k++) begin
            after_tick();
            checks++; if (env !== 8'(8'h40 - 4 * k)) begin errors++; $display("FAIL release_step %0d: got %h want %h", k, env, 8'(8'h40 - 4 * k)); end
        end
        after_tick();
        checks++; if (env !== 8'h00) begin errors++; $display("FAIL release_end_env: got %h want 00", env); end
        checks++; if (state !== 3'd0) begin errors++; $display("FAIL release_end_state: got %0d want 0", state); end
        checks++; if (active !== 1'b0) begin errors++; $display("FAIL release_end_active: got %b want 0", active); end
    endtask

    task automatic test_zero_rates();
        attack_rate = 8'h00; decay_rate = 8'h00;
        sustain_level = 8'h30; release_rate = 8'h40;
        off_tick();
        gate = 1'b1;
        @(negedge clk);
        checks++; if (state !== 3'd1) begin errors++; $display("FAIL zero_attack_enter: got %0d want 1", state); end
        after_tick();
        checks++; if (env !== 8'hFF) begin errors++; $display("FAIL zero_attack_env: got %h want ff", env); end
        checks++; if (state !== 3'd2) begin errors++; $display("FAIL zero_attack_state: got %0d want 2", state); end
        after_tick();
        checks++; if (env !== 8'h30) begin errors++; $display("FAIL zero_decay_env: got %h want 30", env); end
        checks++; if (state !== 3'd3) begin errors++; $display("FAIL zero_decay_state: got %0d want 3", state); end
    endtask

    task automatic test_retrigger();
        attack_rate = 8'h10;
        for (int i = 0; i < 8 && tb_cnt != 0; i++) @(negedge clk);
        gate = 1'b0;
        @(negedge clk);
        checks++; if (state !== 3'd4) begin errors++; $display("FAIL retrig_release_state: got %0d want 4", state); end
        checks++; if (env !== 8'h30) begin errors++; $display("FAIL retrig_release_env: got %h want 30", env); end
        gate = 1'b1;
        @(negedge clk);
        checks++; if (state !== 3'd1) begin errors++; $display("FAIL retrig_state: got %0d want 1", state); end
        checks++; if (env !== 8'h30) begin errors++; $display("FAIL retrig_env: got %h want 30", env); end
        to_pre_tick();
        gate = 1'b0;
        @(negedge clk);
        checks++; if (state !== 3'd4) begin errors++; $display("FAIL fall_on_tick_state: got %0d want 4", state); end
        checks++; if (env !== 8'h30) begin errors++; $display("FAIL fall_on_tick_env: got %h want 30", env); end
        to_pre_tick();
        gate = 1'b1;
        @(negedge clk);
        checks++; if (state !== 3'd1) begin errors++; $display("FAIL rise_on_tick_state: got %0d want 1", state); end
        checks++; if (env !== 8'h30) begin errors++; $display("FAIL rise_on_tick_env: got %h want 30", env); end
        after_tick();
        checks++; if (env !== 8'h31) begin errors++; $display("FAIL retrig_next_step: got %h want 31", env); end
    endtask

    task automatic test_zero_release();
        off_tick();
        gate = 1'b0;
        release_rate = 8'h00;
        @(negedge clk);
        checks++; if (state !== 3'd4) begin errors++; $display("FAIL zero_release_enter: got %0d want 4", state); end
        after_tick();
        checks++; if (state !== 3'd0) begin errors++; $display("FAIL zero_release_state: got %0d want 0", state); end
        checks++; if (env !== 8'h00) begin errors++; $display("FAIL zero_release_env: got %h want 00", env); end
    endtask

    task automatic test_reset_mid();
        attack_rate = 8'h10; release_rate = 8'h40;
        off_tick();
        gate = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 128; i++) after_tick();
        checks++; if (env !== 8'h80) begin errors++; $display("FAIL midreset_pre_env: got %h want 80", env); end
        reset = 1'b1;
        @(negedge clk);
        checks++; if (env !== 8'h00) begin errors++; $display("FAIL midreset_env: got %h want 00", env); end
        checks++; if (state !== 3'd0) begin errors++; $display("FAIL midreset_state: got %0d want 0", state); end
        reset = 1'b0;
        @(negedge clk);
        checks++; if (state !== 3'd1) begin errors++; $display("FAIL midreset_rearm_state: got %0d want 1", state); end
        checks++; if (env !== 8'h00) begin errors++; $display("FAIL midreset_rearm_env: got %h want 00", env); end
        after_tick();
        checks++; if (env !== 8'h01) begin errors++; $display("FAIL midreset_resume: got %h want 01", env); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_attack();
        test_decay();
        test_release();
        test_zero_rates();
        test_retrigger();
        test_zero_release();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
